beam_thresh_loader: RTL and testbench

- Controller that owns the threshold load path of the dual-beam trigger array. Software writes per-beam thresholds into a shadow register file at any time.
- On commit, the block streams the shadow contents into the DSP threshold cascade, then pulses the update strobe so all beams switch thresholds on the same cycle.
- Sits between the register interface (same clock domain) and the thresh_i / thresh_wr_i / thresh_update_i inputs of the beamform trigger.

---
 rtl/beam_thresh_pkg.sv | 29 ++
 rtl/beam_thresh_shadow.sv | 104 ++++++++++
 rtl/beam_thresh_loader.sv | 205 ++++++++++++++++++++
 tb/tb_beam_thresh_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_thresh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beam_thresh_pkg
// Description : Shared types and constants for the beam threshold loader:
//               threshold type and loader state encodings, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package beam_thresh_pkg;

    // Threshold type index on the 36-bit cascade bus
    typedef enum logic {
        TRIG  = 1'b0,
        SERVO = 1'b1
    } thresh_type_e;

    // Loader sequencing states
    typedef enum logic [2:0] {
        LS_IDLE   = 3'd0,
        LS_LOAD   = 3'd1,
        LS_SETTLE = 3'd2,
        LS_UPDATE = 3'd3,
        LS_DONE   = 3'd4
    } loader_state_e;

    localparam int          TBITS_C          = 18;
    localparam logic [17:0] DEFAULT_THRESH_C = 18'h3FFFF;

endpackage : beam_thresh_pkg
`default_nettype wire

// File: rtl/beam_thresh_shadow.sv
`default_nettype none
// ============================================================================
// Module      : beam_thresh_shadow
// Description : NTYPES x NBEAMS shadow threshold register file. One write
//               port, a per-beam streaming read port returning every type at
//               once, and an optional registered readback port.
// Config      : BEAM_THRESH_READBACK_EN adds the readback port.
// Revision    : 1.0 - initial release
// ============================================================================
module beam_thresh_shadow
    import beam_thresh_pkg::*;
#(
    parameter int               NBEAMS         = 2,
    parameter int               NTYPES         = 2,
    parameter int               TBITS          = TBITS_C,
    parameter logic [TBITS-1:0] DEFAULT_THRESH = DEFAULT_THRESH_C,
    localparam int              AW             = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic                    wr_sel_i,
    input  logic [TBITS-1:0]        wr_data_i,
    input  logic [AW-1:0]           strm_addr_i,
    output logic [NTYPES*TBITS-1:0] strm_data_o
`ifdef BEAM_THRESH_READBACK_EN
    ,
    input  logic [AW-1:0]           rd_addr_i,
    input  logic                    rd_sel_i,
    output logic [TBITS-1:0]        rd_data_o
`endif
);

    logic [TBITS-1:0] mem_q  [NTYPES][NBEAMS];
    logic [TBITS-1:0] strm_w [NTYPES];

    // Entry storage; addresses with no matching beam simply match nothing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < NTYPES; t++) begin
                for (int b = 0; b < NBEAMS; b++) begin
                    mem_q[t][b] <= DEFAULT_THRESH;
                end
            end
        end else if (wr_i) begin
            for (int t = 0; t < NTYPES; t++) begin
                for (int b = 0; b < NBEAMS; b++) begin
                    if ((wr_sel_i == 1'(t)) && (wr_addr_i == AW'(b))) begin
                        mem_q[t][b] <= wr_data_i;
                    end
                end
            end
        end
    end

    // Streaming read: all types of the selected beam, zero if out of range
    always_comb begin
        for (int t = 0; t < NTYPES; t++) begin
            strm_w[t] = '0;
            for (int b = 0; b < NBEAMS; b++) begin
                if (strm_addr_i == AW'(b)) begin
                    strm_w[t] = mem_q[t][b];
                end
            end
        end
    end

    generate
        for (genvar t = 0; t < NTYPES; t++) begin : g_strm
            assign strm_data_o[t*TBITS +: TBITS] = strm_w[t];
        end
    endgenerate

`ifdef BEAM_THRESH_READBACK_EN
    logic [TBITS-1:0] rd_d;
    logic [TBITS-1:0] rd_q;

    // Readback mux; an address beyond the last beam returns zero
    always_comb begin
        rd_d = '0;
        for (int t = 0; t < NTYPES; t++) begin
            for (int b = 0; b < NBEAMS; b++) begin
                if ((rd_sel_i == 1'(t)) && (rd_addr_i == AW'(b))) begin
                    rd_d = mem_q[t][b];
                end
            end
        end
    end

    // Readback data registered: valid one cycle after the address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data_o = rd_q;
`endif

endmodule : beam_thresh_shadow
`default_nettype wire

// File: rtl/beam_thresh_loader.sv
`default_nettype none
// ============================================================================
// Module      : beam_thresh_loader
// Description : Owns the threshold load path of the dual-beam trigger array.
//               On commit, streams shadow thresholds into the DSP cascade
//               (highest beam first), waits SETTLE_CYCLES, then pulses the
//               update strobe so every beam switches on the same cycle.
//               Commits arriving while busy collapse into a single reload.
// Config      : BEAM_THRESH_READBACK_EN adds shadow readback and loaded_o.
// Revision    : 1.0 - initial release
// ============================================================================
module beam_thresh_loader
    import beam_thresh_pkg::*;
#(
    parameter int               NBEAMS         = 2,
    parameter int               NTYPES         = 2,
    parameter int               TBITS          = TBITS_C,
    parameter int               SETTLE_CYCLES  = 3,
    parameter logic [TBITS-1:0] DEFAULT_THRESH = DEFAULT_THRESH_C,
    localparam int              AW             = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_wr_i,
    input  logic [AW-1:0]           cfg_addr_i,
    input  logic                    cfg_sel_i,
    input  logic [TBITS-1:0]        cfg_data_i,
    input  logic                    cfg_commit_i,
    input  logic [NTYPES-1:0]       cfg_mask_i,
`ifdef BEAM_THRESH_READBACK_EN
    input  logic [AW-1:0]           cfg_rd_addr_i,
    input  logic                    cfg_rd_sel_i,
    output logic [TBITS-1:0]        cfg_rdata_o,
    output logic                    loaded_o,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic [NTYPES*TBITS-1:0] thresh_o,
    output logic [NTYPES-1:0]       thresh_wr_o,
    output logic [NTYPES-1:0]       thresh_update_o
);

    localparam logic [2:0] ST_IDLE   = LS_IDLE;
    localparam logic [2:0] ST_LOAD   = LS_LOAD;
    localparam logic [2:0] ST_SETTLE = LS_SETTLE;
    localparam logic [2:0] ST_UPDATE = LS_UPDATE;
    localparam logic [2:0] ST_DONE   = LS_DONE;

    localparam logic [3:0]    SETTLE_C   = 4'(SETTLE_CYCLES);
    localparam logic [AW-1:0] LAST_BEAM_C = AW'(NBEAMS - 1);

    logic [2:0]               state_q,  state_d;
    logic [AW-1:0]            cnt_q,    cnt_d;
    logic [3:0]               settle_q, settle_d;
    logic [NTYPES-1:0]        mask_q,   mask_d;
    logic                     pend_q,   pend_d;
    logic [NTYPES-1:0]        pmask_q,  pmask_d;
    logic                     busy_q,   busy_d;
    logic                     done_q,   done_d;
    logic [NTYPES-1:0]        wr_q,     wr_d;
    logic [NTYPES-1:0]        upd_q,    upd_d;
    logic [NTYPES*TBITS-1:0]  thresh_q, thresh_d;

    logic [NTYPES*TBITS-1:0]  strm_data_w;
    logic [NTYPES-1:0]        start_mask_w;

    beam_thresh_shadow #(
        .NBEAMS         (NBEAMS),
        .NTYPES         (NTYPES),
        .TBITS          (TBITS),
        .DEFAULT_THRESH (DEFAULT_THRESH)
    ) u_shadow (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_i        (cfg_wr_i),
        .wr_addr_i   (cfg_addr_i),
        .wr_sel_i    (cfg_sel_i),
        .wr_data_i   (cfg_data_i),
        .strm_addr_i (cnt_q),
`ifdef BEAM_THRESH_READBACK_EN
        .rd_addr_i   (cfg_rd_addr_i),
        .rd_sel_i    (cfg_rd_sel_i),
        .rd_data_o   (cfg_rdata_o),
`endif
        .strm_data_o (strm_data_w)
    );

    // Mask for a sequence launched from IDLE: fresh commit plus anything pending
    assign start_mask_w = (cfg_mask_i & {NTYPES{cfg_commit_i}}) | pmask_q;

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        mask_d   = mask_q;
        pend_d   = pend_q;
        pmask_d  = pmask_q;
        busy_d   = busy_q;
        thresh_d = thresh_q;
        done_d   = 1'b0;
        wr_d     = '0;
        upd_d    = '0;

        // Commits outside IDLE (DONE included) queue up for one reload
        if (cfg_commit_i && (state_q != ST_IDLE)) begin
            pend_d  = 1'b1;
            pmask_d = pmask_q | cfg_mask_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_commit_i || pend_q) begin
                    mask_d   = start_mask_w;
                    pend_d   = 1'b0;
                    pmask_d  = '0;
                    busy_d   = 1'b1;
                    cnt_d    = LAST_BEAM_C;
                    settle_d = SETTLE_C;
                    state_d  = (start_mask_w == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                wr_d     = mask_q;
                thresh_d = strm_data_w;
                if (cnt_q == '0) begin
                    state_d = (SETTLE_C == 4'd0) ? ST_UPDATE : ST_SETTLE;
                end else begin
                    cnt_d = cnt_q - AW'(1);
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                upd_d   = mask_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            mask_q   <= '0;
            pend_q   <= 1'b0;
            pmask_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_q     <= '0;
            upd_q    <= '0;
            thresh_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            pmask_q  <= pmask_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_q     <= wr_d;
            upd_q    <= upd_d;
            thresh_q <= thresh_d;
        end
    end

`ifdef BEAM_THRESH_READBACK_EN
    logic loaded_q;

    // Sticky flag raised together with the first update pulse after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loaded_q <= 1'b0;
        end else if (state_q == ST_UPDATE) begin
            loaded_q <= 1'b1;
        end
    end

    assign loaded_o = loaded_q;
`endif

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign thresh_o        = thresh_q;
    assign thresh_wr_o     = wr_q;
    assign thresh_update_o = upd_q;

endmodule : beam_thresh_loader
`default_nettype wire

// File: tb/tb_beam_thresh_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_beam_thresh_loader
// Description : Directed bench for beam_thresh_loader. Main instance uses
//               NBEAMS=4, SETTLE_CYCLES=3; a second instance uses
//               SETTLE_CYCLES=0. Outputs are logged per cycle relative to a
//               commit (cycle 0 = commit sampling edge) and compared against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_thresh_loader;

    localparam int NB = 4;
    localparam logic [35:0] DEF2 = {18'h3FFFF, 18'h3FFFF};

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cfg_wr_i;
    logic [1:0]  cfg_addr_i;
    logic        cfg_sel_i;
    logic [17:0] cfg_data_i;
    logic        cfg_commit_i, cmt1;
    logic [1:0]  cfg_mask_i, msk1;

    logic        busy_o, done_o, busy1, done1;
    logic [35:0] thresh_o, th1;
    logic [1:0]  thresh_wr_o, thresh_update_o, wr1, up1;

`ifdef BEAM_THRESH_READBACK_EN
    logic [1:0]  rd_addr = '0;
    logic        rd_sel  = 1'b0;
    logic [17:0] rdata0, rdata1;
    logic        loaded0, loaded1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;

    logic [35:0] l_th  [64];
    logic [1:0]  l_wr  [64];
    logic [1:0]  l_up  [64];
    logic        l_dn  [64];
    logic        l_bz  [64];
    logic [1:0]  l_wr1 [64];
    logic [1:0]  l_up1 [64];
    logic        l_dn1 [64];

    always #5 clk_i = ~clk_i;

    beam_thresh_loader #(.NBEAMS(NB), .SETTLE_CYCLES(3)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cfg_wr_i        (cfg_wr_i),
        .cfg_addr_i      (cfg_addr_i),
        .cfg_sel_i       (cfg_sel_i),
        .cfg_data_i      (cfg_data_i),
        .cfg_commit_i    (cfg_commit_i),
        .cfg_mask_i      (cfg_mask_i),
`ifdef BEAM_THRESH_READBACK_EN
        .cfg_rd_addr_i   (rd_addr),
        .cfg_rd_sel_i    (rd_sel),
        .cfg_rdata_o     (rdata0),
        .loaded_o        (loaded0),
`endif
        .busy_o          (busy_o),
        .done_o          (done_o),
        .thresh_o        (thresh_o),
        .thresh_wr_o     (thresh_wr_o),
        .thresh_update_o (thresh_update_o)
    );

    beam_thresh_loader #(.NBEAMS(NB), .SETTLE_CYCLES(0)) dut_s0 (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cfg_wr_i        (cfg_wr_i),
        .cfg_addr_i      (cfg_addr_i),
        .cfg_sel_i       (cfg_sel_i),
        .cfg_data_i      (cfg_data_i),
        .cfg_commit_i    (cmt1),
        .cfg_mask_i      (msk1),
`ifdef BEAM_THRESH_READBACK_EN
        .cfg_rd_addr_i   (rd_addr),
        .cfg_rd_sel_i    (rd_sel),
        .cfg_rdata_o     (rdata1),
        .loaded_o        (loaded1),
`endif
        .busy_o          (busy1),
        .done_o          (done1),
        .thresh_o        (th1),
        .thresh_wr_o     (wr1),
        .thresh_update_o (up1)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock, sample 1 ns after the edge and log the outputs
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (cyc >= 0 && cyc < 64) begin
            l_th[cyc]  = thresh_o;
            l_wr[cyc]  = thresh_wr_o;
            l_up[cyc]  = thresh_update_o;
            l_dn[cyc]  = done_o;
            l_bz[cyc]  = busy_o;
            l_wr1[cyc] = wr1;
            l_up1[cyc] = up1;
            l_dn1[cyc] = done1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Commit on the main instance; the commit edge becomes logged cycle 0
    task automatic commit0(input logic [1:0] m);
        cyc          = -1;
        cfg_commit_i = 1'b1;
        cfg_mask_i   = m;
        tick();
        cfg_commit_i = 1'b0;
        cfg_mask_i   = 2'b00;
    endtask

    task automatic shadow_wr(input logic [1:0] b, input logic s, input logic [17:0] d);
        cfg_wr_i   = 1'b1;
        cfg_addr_i = b;
        cfg_sel_i  = s;
        cfg_data_i = d;
        tick();
        cfg_wr_i   = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        cfg_wr_i = 1'b0; cfg_addr_i = '0; cfg_sel_i = 1'b0; cfg_data_i = '0;
        cfg_commit_i = 1'b0; cfg_mask_i = '0; cmt1 = 1'b0; msk1 = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_busy",   64'(busy_o), 64'd0);
        check_eq("rst_done",   64'(done_o), 64'd0);
        check_eq("rst_wr",     64'(thresh_wr_o), 64'd0);
        check_eq("rst_update", 64'(thresh_update_o), 64'd0);
        check_eq("rst_thresh", 64'(thresh_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run(2);

        // Default contents streamed, update at cycle 8, done at cycle 9
        commit0(2'b11);
        run(12);
        check_eq("t1_busy_c0", 64'(l_bz[0]), 64'd1);
        check_eq("t1_wr_c0",   64'(l_wr[0]), 64'd0);
        for (int c = 1; c <= 4; c++) begin
            check_eq($sformatf("t1_wr_c%0d", c), 64'(l_wr[c]), 64'd3);
            check_eq($sformatf("t1_th_c%0d", c), 64'(l_th[c]), 64'(DEF2));
        end
        for (int c = 5; c <= 7; c++) begin
            check_eq($sformatf("t1_wr_c%0d", c), 64'(l_wr[c]), 64'd0);
            check_eq($sformatf("t1_up_c%0d", c), 64'(l_up[c]), 64'd0);
        end
        check_eq("t1_up_c8",    64'(l_up[8]), 64'd3);
        check_eq("t1_done_c8",  64'(l_dn[8]), 64'd0);
        check_eq("t1_done_c9",  64'(l_dn[9]), 64'd1);
        check_eq("t1_up_c9",    64'(l_up[9]), 64'd0);
        check_eq("t1_done_c10", 64'(l_dn[10]), 64'd0);
        check_eq("t1_busy_c11", 64'(l_bz[11]), 64'd0);

        // Ordering: trig[b] = 0x100+b, streamed highest beam first
        for (int b = 0; b < NB; b++) shadow_wr(2'(b), 1'b0, 18'h100 + 18'(b));
        commit0(2'b01);
        run(12);
        for (int c = 1; c <= 4; c++) begin
            check_eq($sformatf("t2_trig_c%0d", c), 64'(l_th[c][17:0]), 64'(18'h104 - 18'(c)));
            check_eq($sformatf("t2_wr_c%0d", c), 64'(l_wr[c]), 64'd1);
        end
        check_eq("t2_servo_c1", 64'(l_th[1][35:18]), 64'h3FFFF);
        check_eq("t2_up_c7", 64'(l_up[7]), 64'd0);
        check_eq("t2_up_c8", 64'(l_up[8]), 64'd1);
        check_eq("t2_up_c9", 64'(l_up[9]), 64'd0);
        check_eq("t2_th_hold_c9", 64'(l_th[9][17:0]), 64'h100);

        // Three commits while busy (last one during DONE) -> one reload, mask 10
        commit0(2'b01);
        tick();                                           // c1
        cfg_commit_i = 1'b1; cfg_mask_i = 2'b10; tick();  // c2
        cfg_commit_i = 1'b0; cfg_mask_i = 2'b00; run(2);  // c3,c4
        cfg_commit_i = 1'b1; cfg_mask_i = 2'b10; tick();  // c5
        cfg_commit_i = 1'b0; cfg_mask_i = 2'b00; run(3);  // c6..c8
        cfg_commit_i = 1'b1; cfg_mask_i = 2'b00; tick();  // c9 (DONE)
        cfg_commit_i = 1'b0;
        run(25);                                          // c10..c34
        check_eq("t3_wr_c1",    64'(l_wr[1]), 64'd1);
        check_eq("t3_up_c8",    64'(l_up[8]), 64'd1);
        check_eq("t3_done_c9",  64'(l_dn[9]), 64'd1);
        check_eq("t3_busy_c10", 64'(l_bz[10]), 64'd1);
        check_eq("t3_wr_c10",   64'(l_wr[10]), 64'd0);
        for (int c = 11; c <= 14; c++)
            check_eq($sformatf("t3_wr_c%0d", c), 64'(l_wr[c]), 64'd2);
        check_eq("t3_up_c18",   64'(l_up[18]), 64'd2);
        check_eq("t3_done_c19", 64'(l_dn[19]), 64'd1);
        for (int c = 20; c <= 34; c++) begin
            check_eq($sformatf("t3_extra_wr_c%0d", c), 64'(l_wr[c]), 64'd0);
            check_eq($sformatf("t3_extra_done_c%0d", c), 64'(l_dn[c]), 64'd0);
        end

        // Writes during LOAD: beam 0 not yet streamed, beam 3 already streamed
        commit0(2'b11);
        shadow_wr(2'd0, 1'b0, 18'h55);                   // c1
        shadow_wr(2'd3, 1'b0, 18'h77);                   // c2
        run(10);
        check_eq("t4_b3_old", 64'(l_th[1][17:0]), 64'h103);
        check_eq("t4_b2",     64'(l_th[2][17:0]), 64'h102);
        check_eq("t4_b1",     64'(l_th[3][17:0]), 64'h101);
        check_eq("t4_b0_new", 64'(l_th[4][17:0]), 64'h55);
        commit0(2'b01);
        run(11);
        check_eq("t4_b3_next", 64'(l_th[1][17:0]), 64'h77);
        check_eq("t4_b0_next", 64'(l_th[4][17:0]), 64'h55);

        // Reset during LOAD cycle 2
        commit0(2'b11);
        run(2);
        rst_ni = 1'b0;
        #1;
        check_eq("t5_rst_wr",     64'(thresh_wr_o), 64'd0);
        check_eq("t5_rst_thresh", 64'(thresh_o), 64'd0);
        check_eq("t5_rst_busy",   64'(busy_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc = -1;
        run(12);
        for (int c = 0; c < 12; c++) begin
            check_eq($sformatf("t5_no_up_c%0d", c), 64'(l_up[c]), 64'd0);
            check_eq($sformatf("t5_no_done_c%0d", c), 64'(l_dn[c]), 64'd0);
        end
        commit0(2'b11);
        run(11);
        check_eq("t5_default_b3", 64'(l_th[1]), 64'(DEF2));
        check_eq("t5_default_b0", 64'(l_th[4]), 64'(DEF2));

        // Mask 0: straight to done, no writes, no update
        commit0(2'b00);
        run(5);
        check_eq("t6_busy_c0", 64'(l_bz[0]), 64'd1);
        check_eq("t6_done_c0", 64'(l_dn[0]), 64'd0);
        check_eq("t6_done_c1", 64'(l_dn[1]), 64'd1);
        check_eq("t6_done_c2", 64'(l_dn[2]), 64'd0);
        for (int c = 0; c <= 5; c++) begin
            check_eq($sformatf("t6_wr_c%0d", c), 64'(l_wr[c]), 64'd0);
            check_eq($sformatf("t6_up_c%0d", c), 64'(l_up[c]), 64'd0);
        end

        // SETTLE_CYCLES = 0 instance: update right after the last write
        cyc = -1;
        cmt1 = 1'b1; msk1 = 2'b11;
        tick();
        cmt1 = 1'b0; msk1 = 2'b00;
        run(8);
        for (int c = 1; c <= 4; c++)
            check_eq($sformatf("t7_wr_c%0d", c), 64'(l_wr1[c]), 64'd3);
        check_eq("t7_up_c4",   64'(l_up1[4]), 64'd0);
        check_eq("t7_up_c5",   64'(l_up1[5]), 64'd3);
        check_eq("t7_wr_c5",   64'(l_wr1[5]), 64'd0);
        check_eq("t7_done_c6", 64'(l_dn1[6]), 64'd1);
        check_eq("t7_up_c6",   64'(l_up1[6]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_beam_thresh_loader
`default_nettype wire
